alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters (e.g. main datapath and an address/branch unit).
//  Round-robin arbitration, valid/ready request and response handshakes.
//  Operands and op are latched and driven to the ALU, and result/zero are registered back per requester.
//  Sits between the requesters and the ALU instance; the ALU itself is unchanged.
// PARAMETERS
//  WIDTH  32  operand/result width
//  OPW    3   ALU op width; codes 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 zero-compare
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req0_valid   in   1      requester 0 has an op
//  req0_op      in   OPW    requester 0 ALU op
//  req0_a       in   WIDTH  requester 0 operand A
//  req0_b       in   WIDTH  requester 0 operand B
//  req0_ready   out  1      requester 0 op accepted this cycle
//  rsp0_valid   out  1      response for requester 0 available
//  rsp0_ready   in   1      requester 0 consumes response
//  req1_*, rsp1_*           identical set for requester 1
//  rsp_result   out  WIDTH  registered ALU result (shared by both rsp ports)
//  rsp_zero     out  1      registered ALU zero flag
//  alu_op       out  OPW    to ALU aluop
//  alu_a        out  WIDTH  to ALU vsrc1
//  alu_b        out  WIDTH  to ALU vsrc2
//  alu_result   in   WIDTH  from ALU result
//  alu_zero     in   1      from ALU zero
//  busy         out  1      high in EXEC or RESP
// BEHAVIOUR
//  - FSM states IDLE -> EXEC -> RESP -> IDLE. Reset: IDLE, last_grant=1 (req0 wins first), op/a/b/result/zero regs=0, all valid/ready/busy=0.
//  - IDLE: grant = req0 if only req0_valid, req1 if only req1_valid; if both, the one != last_grant.
//    reqN_ready = (state==IDLE) & grantN (combinational). On accept, latch op/a/b, record owner, go EXEC.
//  - EXEC (1 cycle): alu_* held from latched regs; capture alu_result/alu_zero into rsp regs; go RESP.
//  - RESP: rspN_valid=1 for owner only; rsp_result/rsp_zero stable. On rspN_ready: last_grant=owner, go IDLE.
//    rspN_ready on the non-owner port is ignored.
//  - Latency: accept at edge T -> rsp valid from T+2. Max throughput 1 op per 3 cycles with rsp_ready high.
//  - No request is accepted outside IDLE. reqN_ready never rises in the same cycle as a response handshake.
//  - alu_op/a/b always equal the latched regs (0 after reset). Ops 110/111 are passed through and their result is whatever the ALU returns.
//  - No arithmetic in this block; widths pass straight through.
//  - Reset mid-operation (EXEC or RESP): in-flight op discarded, no response, return to reset state.
//  - Requester must hold req fields stable while valid&!ready (not checked).
// CONFIGURATION
//  ALU_ARB_PERF_EN defined: adds outputs grant0_cnt, grant1_cnt (32b each).
//    Each counts accepted requests for its requester, wraps 0xFFFFFFFF->0, and is cleared by rst.
//  Not defined: counter ports and logic absent; all other behaviour identical.
// TESTING
//  1 Reset with all inputs 0 -> every output 0, busy=0, req0_ready=req1_ready=0.
//  2 req0 add a=5 b=7, rsp0_ready=1 -> req0_ready at T; rsp0_valid at T+2; rsp_result=12, rsp_zero=0; rsp1_valid stays 0.
//  3 Both valid continuously, op sub a=10 b=3 -> grants alternate 0,1,0,1.
//    Each rsp_result=7 on the owner's port only; an op completes every 3 cycles.
//  4 req1 op 101 a=b=0x1234 -> rsp_zero=1.
//    Then req1 slt a=0xFFFFFFFF b=1 -> rsp_result=1.
//  5 rsp0_ready low 5 cycles with req1_valid high -> rsp0_valid and data stable, busy=1, req1_ready=0.
//    Release -> req1 accepted the cycle after the handshake.
//  6 rst pulse during EXEC -> no rsp_valid, outputs 0; next req0 and 2 b=2 -> result 2.
//    With ALU_ARB_PERF_EN: counters reset to 0 and then show 1/0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU: IDLE -> EXEC -> RESP.
// Optional ALU_ARB_PERF_EN adds per-requester accepted-request counters (grant0_cnt, grant1_cnt).
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]      grant0_cnt,
  output logic [31:0]      grant1_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic             busy_q;

  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic             rsp_hs;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0 = last_grant_q;
      gnt1 = ~last_grant_q;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  assign req0_ready = (state_q == ST_IDLE) & gnt0;
  assign req1_ready = (state_q == ST_IDLE) & gnt1;
  assign accept     = req0_ready | req1_ready;
  assign rsp_hs     = (state_q == ST_RESP) & (owner_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= gnt1;
            op_q    <= gnt1 ? req1_op : req0_op;
            a_q     <= gnt1 ? req1_a  : req0_a;
            b_q     <= gnt1 ? req1_b  : req0_b;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q     <= alu_result;
          zero_q       <= alu_zero;
          rsp0_valid_q <= ~owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            last_grant_q <= owner_q;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = busy_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant0_cnt_q;
  logic [31:0] grant1_cnt_q;

  // Free-running wrap at 2^32 is intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
    end else begin
      if (req0_ready) grant0_cnt_q <= grant0_cnt_q + 32'd1;
      if (req1_ready) grant1_cnt_q <= grant1_cnt_q + 32'd1;
    end
  end

  assign grant0_cnt = grant0_cnt_q;
  assign grant1_cnt = grant1_cnt_q;
`endif

endmodule
